am_demodulator: RTL and testbench

- Envelope-detecting AM demodulator.
- Takes complex AM samples in the modulator's output format and estimates the envelope magnitude with a pipelined alpha-max-beta-min approximation.
- Removes the carrier DC level with a leaky-integrator tracker, then rescales by the reciprocal modulation index.
- Recovers baseband in the same Q1.11 format the modulator consumes; sits on the receive path after the channel/IQ front end.

---
 rtl/am_demodulator.sv | 144 ++++++++++++++
 tb/tb_am_demodulator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/am_demodulator.sv
//==============================================================================
// Module      : am_demodulator
// Description : Envelope-detecting AM demodulator. Four-stage pipeline:
//               S1 absolute value, S2 alpha-max-beta-min magnitude,
//               S3 leaky-integrator carrier (DC) removal, S4 rescale by 1/m
//               with saturation to Q1.11.
// Ports       : i_clk            clock, rising edge
//               i_rst_n          asynchronous active-low reset
//               enable           block enable, low = synchronous flush
//               i_valid          input sample strobe
//               i_am_i/i_am_q    signed 12-bit samples, 8 fractional bits
//               i_inv_mod_index  1/m, unsigned Q4.12
//               o_valid          one-cycle strobe per output sample
//               o_baseband       recovered baseband, signed Q1.11
//               o_dc_level       carrier-level estimate, unsigned, frac 8
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module am_demodulator #(
  parameter int DC_SHIFT = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        enable,
  input  logic        i_valid,
  input  logic [11:0] i_am_i,
  input  logic [11:0] i_am_q,
  input  logic [15:0] i_inv_mod_index,
  output logic        o_valid,
  output logic [11:0] o_baseband,
  output logic [11:0] o_dc_level
);

  // Accumulator width: steady state with mag=4095 keeps acc below 4096*2^K.
  localparam int c_ACC_W = 12 + DC_SHIFT;

  // |x| limited to 11 bits; -2048 has no positive twin so it saturates.
  function automatic logic [10:0] abs_sat(input logic [11:0] x);
    logic [10:0] r;
    if (!x[11])
      r = x[10:0];
    else if (x[10:0] == 11'd0)
      r = 11'h7FF;
    else
      r = ~x[10:0] + 11'd1;
    return r;
  endfunction

  logic [3:0]         r_vld;
  logic [10:0]        r_abs_i;
  logic [10:0]        r_abs_q;
  logic [11:0]        r_mag;
  logic [c_ACC_W-1:0] r_acc;
  logic signed [12:0] r_ac;
  logic [11:0]        r_dc;

  logic [10:0]        w_mx;
  logic [10:0]        w_mn;
  logic [11:0]        w_mag;
  logic [11:0]        w_dc_pre;
  logic [c_ACC_W-1:0] w_acc_next;
  logic [11:0]        w_dc_post;
  logic signed [12:0] w_ac;
  logic signed [29:0] w_prod;
  logic signed [29:0] w_shift;
  logic [11:0]        w_bb_sat;

  // S2: alpha = 15/16, beta = 15/32; each shift truncates independently.
  always_comb begin
    w_mx  = (r_abs_i >= r_abs_q) ? r_abs_i : r_abs_q;
    w_mn  = (r_abs_i >= r_abs_q) ? r_abs_q : r_abs_i;
    w_mag = {1'b0, w_mx} - {5'b0, w_mx[10:4]}
          + {2'b0, w_mn[10:1]} - {6'b0, w_mn[10:5]};
  end

  // S3: dc comes from the pre-update accumulator. The sum may pass through
  // the top bit transiently, but the final value always fits, so modular
  // arithmetic gives the exact result.
  always_comb begin
    w_dc_pre   = r_acc[c_ACC_W-1:DC_SHIFT];
    w_acc_next = r_acc + c_ACC_W'(r_mag) - c_ACC_W'(w_dc_pre);
    w_dc_post  = w_acc_next[c_ACC_W-1:DC_SHIFT];
    w_ac       = $signed({1'b0, r_mag}) - $signed({1'b0, w_dc_pre});
  end

  // S4: both operands widened to 30 bits so the low 30 product bits are
  // exact; |ac*inv| < 2^28 so nothing is lost.
  always_comb begin
    w_prod  = $signed({{17{r_ac[12]}}, r_ac}) * $signed({14'b0, i_inv_mod_index});
    w_shift = w_prod >>> 9;
    if (w_shift[29:11] == {19{w_shift[29]}})
      w_bb_sat = w_shift[11:0];
    else if (w_shift[29])
      w_bb_sat = 12'h800;
    else
      w_bb_sat = 12'h7FF;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld      <= '0;
      r_abs_i    <= '0;
      r_abs_q    <= '0;
      r_mag      <= '0;
      r_acc      <= '0;
      r_ac       <= '0;
      r_dc       <= '0;
      o_baseband <= '0;
      o_dc_level <= '0;
    end else if (!enable) begin
      // Flush: in-flight samples die and the DC tracker restarts from zero.
      r_vld      <= '0;
      r_acc      <= '0;
      o_baseband <= '0;
      o_dc_level <= '0;
    end else begin
      r_vld <= {r_vld[2:0], i_valid};
      if (i_valid) begin
        r_abs_i <= abs_sat(i_am_i);
        r_abs_q <= abs_sat(i_am_q);
      end
      if (r_vld[0]) begin
        r_mag <= w_mag;
      end
      if (r_vld[1]) begin
        r_acc <= w_acc_next;
        r_ac  <= w_ac;
        r_dc  <= w_dc_post;
      end
      // dc level is carried into the output stage so it lines up with o_valid.
      if (r_vld[2]) begin
        o_baseband <= w_bb_sat;
        o_dc_level <= r_dc;
      end
    end
  end

  assign o_valid = r_vld[3];

endmodule

`default_nettype wire

// File: tb/tb_am_demodulator.sv
//==============================================================================
// Module      : tb_am_demodulator
// Description : Self-checking bench for am_demodulator. A queue-based
//               behavioural model predicts o_valid/o_baseband/o_dc_level
//               every cycle; directed phases cover reset, magnitude,
//               carrier tracking, saturation and flush, followed by random
//               traffic with enable drops and a mid-stream reset.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_am_demodulator;

  localparam int c_K = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        vld   = 1'b0;
  logic [11:0] ai    = '0;
  logic [11:0] aq    = '0;
  logic [15:0] inv   = '0;
  logic        o_valid;
  logic [11:0] o_bb;
  logic [11:0] o_dc;

  am_demodulator #(.DC_SHIFT(c_K)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .enable          (en),
    .i_valid         (vld),
    .i_am_i          (ai),
    .i_am_q          (aq),
    .i_inv_mod_index (inv),
    .o_valid         (o_valid),
    .o_baseband      (o_bb),
    .o_dc_level      (o_dc)
  );

  always #5 clk = ~clk;

  // Each in-flight sample carries its AC value and post-update dc level;
  // 'age' counts clock edges since acceptance.
  typedef struct {
    int age;
    int ac;
    int dc;
  } ent_t;

  ent_t   pipe[$];
  longint m_acc = 0;
  int     exp_v  = 0;
  int     exp_bb = 0;
  int     exp_dc = 0;
  int     total  = 0;
  int     bad    = 0;

  function automatic int env(input int i, input int q);
    int a, b, mx, mn;
    a  = (i < 0) ? -i : i;
    b  = (q < 0) ? -q : q;
    if (a > 2047) a = 2047;
    if (b > 2047) b = 2047;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return mx - mx / 16 + mn / 2 - mn / 32;
  endfunction

  function automatic int scale(input int ac, input int iv);
    longint p;
    p = longint'(ac) * longint'(iv);
    p = p >>> 9;
    if (p > 2047)  p = 2047;
    if (p < -2048) p = -2048;
    return int'(p);
  endfunction

  function automatic void model_clear();
    pipe.delete();
    m_acc  = 0;
    exp_v  = 0;
    exp_bb = 0;
    exp_dc = 0;
  endfunction

  // Model the effect of one rising edge with the given inputs.
  function automatic void model_edge(input bit e, input bit v, input int i,
                                     input int q, input int iv);
    ent_t n;
    int   mag, dcp;
    if (!e) begin
      model_clear();
      return;
    end
    exp_v = 0;
    if (pipe.size() > 0 && pipe[0].age == 3) begin
      n      = pipe.pop_front();
      exp_v  = 1;
      exp_bb = scale(n.ac, iv);
      exp_dc = n.dc;
    end
    foreach (pipe[k]) pipe[k].age++;
    if (v) begin
      mag    = env(i, q);
      dcp    = int'(m_acc >>> c_K);
      m_acc  = m_acc + mag - dcp;
      n.age  = 1;
      n.ac   = mag - dcp;
      n.dc   = int'(m_acc >>> c_K);
      pipe.push_back(n);
    end
  endfunction

  task automatic check(input string tag, input int act, input int expv);
    total++;
    assert (act === expv) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, act, expv);
    end
  endtask

  task automatic check_range(input string tag, input int act, input int lo, input int hi);
    total++;
    assert (act >= lo && act <= hi) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, act, lo, hi);
    end
  endtask

  task automatic check_outs();
    check("valid",    int'(o_valid),      exp_v);
    check("baseband", int'($signed(o_bb)), exp_bb);
    check("dc_level", int'(o_dc),         exp_dc);
  endtask

  // Drive one cycle: inputs set just after a falling edge, outputs checked
  // at the next falling edge.
  task automatic cyc(input bit e, input bit v, input int i, input int q, input int iv);
    en  = e;
    vld = v;
    ai  = i[11:0];
    aq  = q[11:0];
    inv = iv[15:0];
    model_edge(e, v, i, q, iv);
    @(negedge clk);
    check_outs();
  endtask

  function automatic int rnd12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  initial begin
    int ri;
    model_clear();

    // Reset held with busy inputs: everything stays zero.
    for (int c = 0; c < 4; c++) begin
      en  = 1'b1;
      vld = 1'b1;
      ai  = 12'($urandom_range(0, 4095));
      aq  = 12'($urandom_range(0, 4095));
      inv = 16'hFFFF;
      @(negedge clk);
      check_outs();
    end
    rst_n = 1'b1;

    // Single sample I=256,Q=0: appears exactly four cycles later.
    cyc(1, 1, 256, 0, 'h2000);
    for (int c = 0; c < 6; c++) cyc(1, 0, 0, 0, 'h2000);

    // Magnitude settling with a fresh tracker.
    cyc(0, 0, 0, 0, 0);
    for (int c = 0; c < 200; c++) cyc(1, 1, 256, 256, 0);
    check_range("mag_256_256", int'(o_dc), 359, 361);
    for (int c = 0; c < 200; c++) cyc(1, 1, -2048, 0, 0);
    check_range("mag_neg2048", int'(o_dc), 1919, 1920);

    // Unmodulated carrier: dc converges to 240 and baseband goes flat.
    cyc(0, 0, 0, 0, 0);
    for (int c = 0; c < 200; c++) cyc(1, 1, 256, 0, 'h2000);
    check("carrier_dc", int'(o_dc), 240);
    check("carrier_bb", int'($signed(o_bb)), 0);

    // Saturation both ways; outputs hold during the idle gaps.
    cyc(1, 1, 2047, 2047, 'hFFFF);
    for (int c = 0; c < 5; c++) cyc(1, 0, 0, 0, 'hFFFF);
    check("sat_pos", int'($signed(o_bb)), 2047);
    cyc(1, 1, 0, 0, 'hFFFF);
    for (int c = 0; c < 5; c++) cyc(1, 0, 0, 0, 'hFFFF);
    check("sat_neg", int'($signed(o_bb)), -2048);

    // One-cycle enable drop in the middle of a stream.
    for (int c = 0; c < 20; c++) cyc(1, 1, 300 + c, -100, 'h1800);
    cyc(0, 1, 500, 500, 'h1800);
    for (int c = 0; c < 20; c++) cyc(1, (c % 3) != 1, 300 - c, 80, 'h1800);

    // Random traffic with occasional enable drops and one async reset.
    ri = int'($urandom_range(0, 65535));
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) ri = int'($urandom_range(0, 65535));
      if (c == 400) begin
        rst_n = 1'b0;
        #1;
        model_clear();
        check_outs();
        vld = 1'b1;
        @(negedge clk);
        check_outs();
        rst_n = 1'b1;
      end
      cyc($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, rnd12(), rnd12(), ri);
    end
    for (int c = 0; c < 6; c++) cyc(1, 0, 0, 0, ri);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
